// File: rtl/serial_sub.sv
// serial_sub: bit-serial WIDTH-bit subtractor (x - y - bi), LSB first,
// through one full-subtractor cell with a registered borrow.
// Handshake: start accepted only in IDLE; done pulses once the result is registered.
module serial_sub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             bi,
  output logic [WIDTH-1:0] z,
  output logic             bo,
  output logic             ov,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t stateCur;
  state_t stateNext;

  logic [WIDTH-1:0] xr;
  logic [WIDTH-1:0] yr;
  logic [WIDTH-2:0] dr;      // difference bits gathered so far, newest at the top
  logic             b;       // running borrow between bit positions
  logic [CNT_W-1:0] cnt;
  logic             xs;      // operand sign bits, kept for the overflow decision
  logic             ys;

  logic             d;
  logic             bNext;
  logic [WIDTH-1:0] accum;
  logic             lastShift;

  // One-bit full subtractor: returns {borrowOut, diff}
  function automatic logic [1:0] subCell(input logic xb, input logic yb, input logic bIn);
    logic diffBit;
    logic borrowOut;
    diffBit   = xb ^ yb ^ bIn;
    borrowOut = (~xb & yb) | (~(xb ^ yb) & bIn);
    return {borrowOut, diffBit};
  endfunction

  // Cell evaluation on the current LSBs and the accumulated difference word
  always_comb begin
    {bNext, d} = subCell(xr[0], yr[0], b);
    accum      = {d, dr};
    lastShift  = (stateCur == SHIFT) && (cnt == CNT_W'(WIDTH - 1));
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) stateCur <= IDLE;
    else     stateCur <= stateNext;
  end

  // Next-state and handshake outputs
  always_comb begin
    stateNext = stateCur;
    busy      = 1'b0;
    done      = 1'b0;
    case (stateCur)
      IDLE: begin
        if (start) stateNext = SHIFT;
      end
      SHIFT: begin
        busy = 1'b1;
        if (lastShift) stateNext = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // Operand capture, serial shifting and final result registration
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xr  <= '0;
      yr  <= '0;
      dr  <= '0;
      b   <= 1'b0;
      cnt <= '0;
      xs  <= 1'b0;
      ys  <= 1'b0;
      z   <= '0;
      bo  <= 1'b0;
      ov  <= 1'b0;
    end else if (stateCur == IDLE) begin
      if (start) begin
        xr  <= x;
        yr  <= y;
        b   <= bi;
        dr  <= '0;
        cnt <= '0;
        xs  <= x[WIDTH-1];
        ys  <= y[WIDTH-1];
      end
    end else if (stateCur == SHIFT) begin
      xr  <= xr >> 1;
      yr  <= yr >> 1;
      b   <= bNext;
      dr  <= accum[WIDTH-1:1];
      cnt <= cnt + CNT_W'(1);
      if (lastShift) begin
        z  <= accum;
        bo <= bNext;
        ov <= (xs != ys) && (d != xs);
      end
    end
  end

endmodule
